// File: rtl/ahb_slave_mem.sv
`default_nettype none
// ============================================================================
// Module      : ahb_slave_mem
// Description : AHB-Lite word-addressed memory slave with a programmable
//               number of wait states per OKAY data phase and a two-cycle
//               ERROR response for out-of-range, misaligned or non-word
//               transfers. Memory is cleared by reset.
// Ports       : hclk/hreset        - clock, asynchronous active-high reset
//               hsel, haddr, htrans,
//               hwrite, hsize,
//               hready             - address-phase inputs
//               hwdata             - write data (data phase)
//               hreadyout, hresp,
//               hrdata             - slave response
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_slave_mem #(
    parameter int unsigned DEPTH       = 16,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [31:0] hwdata,
    input  logic        hready,
    output logic        hreadyout,
    output logic        hresp,
    output logic [31:0] hrdata
);

    localparam int unsigned c_IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [32:0] c_SPAN      = 33'(4 * DEPTH);
    localparam logic [2:0]  c_WAIT_LOAD = 3'(WAIT_STATES);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_DONE = 3'd2,
        S_ERR1 = 3'd3,
        S_ERR2 = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [2:0]           r_cnt;
    logic [c_IDX_W-1:0]   r_idx;
    logic                 r_write;
    logic [31:0]          r_mem [DEPTH];

    logic                 w_accept;
    logic                 w_can_accept;
    logic                 w_take;
    logic                 w_illegal;
    logic [32:0]          w_diff;
    logic                 w_unused_ok;

    // A 33-bit difference makes "below base" visible as a borrow in bit 32,
    // so the lower and upper bound checks share one subtractor.
    assign w_diff       = {1'b0, haddr} - {1'b0, BASE_ADDR};
    assign w_illegal    = w_diff[32]
                       || (w_diff >= c_SPAN)
                       || (haddr[1:0] != 2'b00)
                       || (hsize != 3'b010);

    assign w_accept     = hsel && hready && htrans[1];
    assign w_can_accept = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR2);
    assign w_take       = w_accept && w_can_accept;

    assign w_unused_ok  = ^{w_diff[31:c_IDX_W+2], w_diff[1:0], htrans[0]};

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and response outputs. Outputs depend on state alone (plus
    // the captured direction), so reset forces them without waiting for an
    // edge.
    // ------------------------------------------------------------------------
    always_comb begin
        w_next    = r_state;
        hreadyout = 1'b1;
        hresp     = 1'b0;
        hrdata    = 32'h0;

        case (r_state)
            S_IDLE, S_DONE, S_ERR2: begin
                if (w_accept) begin
                    if (w_illegal) begin
                        w_next = S_ERR1;
                    end else if (c_WAIT_LOAD != 3'd0) begin
                        w_next = S_WAIT;
                    end else begin
                        w_next = S_DONE;
                    end
                end else begin
                    w_next = S_IDLE;
                end

                if (r_state == S_DONE && !r_write) begin
                    hrdata = r_mem[r_idx];
                end
                if (r_state == S_ERR2) begin
                    hresp = 1'b1;
                end
            end
            S_WAIT: begin
                hreadyout = 1'b0;
                // Counter was loaded with the full stall count on entry;
                // the value 1 marks the final stall cycle.
                if (r_cnt <= 3'd1) begin
                    w_next = S_DONE;
                end
            end
            S_ERR1: begin
                hreadyout = 1'b0;
                hresp     = 1'b1;
                w_next    = S_ERR2;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Wait-state down-counter
    // ------------------------------------------------------------------------
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            r_cnt <= 3'd0;
        end else if (w_take && !w_illegal) begin
            r_cnt <= c_WAIT_LOAD;
        end else if (r_state == S_WAIT && r_cnt != 3'd0) begin
            r_cnt <= r_cnt - 3'd1;
        end
    end

    // ------------------------------------------------------------------------
    // Address-phase capture: only the word index and direction are needed
    // later, legality has already been resolved into the state transition.
    // ------------------------------------------------------------------------
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            r_idx   <= '0;
            r_write <= 1'b0;
        end else if (w_take) begin
            r_idx   <= w_diff[c_IDX_W+1:2];
            r_write <= hwrite;
        end
    end

    // ------------------------------------------------------------------------
    // Storage: written only on the edge that ends a write's DONE cycle.
    // ------------------------------------------------------------------------
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= 32'h0;
            end
        end else if (r_state == S_DONE && r_write) begin
            r_mem[r_idx] <= hwdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ahb_slave_mem.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahb_slave_mem
// Description : Self-checking bench for ahb_slave_mem. Two instances are
//               exercised: one with a single wait state and one with none.
//               Expected responses come from a transfer-level model: each
//               legal transfer takes WAIT_STATES+1 data cycles, each illegal
//               one takes two ERROR cycles, memory changes only when a legal
//               write completes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_slave_mem;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] data;
    } xfer_t;

    logic        hclk = 1'b0;
    logic        hreset;
    logic        hsel_a, hsel_b;
    logic [31:0] haddr, hwdata;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic        ext_stall;
    logic        hready;
    logic        ro_a, resp_a, ro_b, resp_b;
    logic [31:0] rd_a, rd_b;

    int          checks   = 0;
    int          failures = 0;

    logic [31:0] mdl [2][16];
    xfer_t       q [$];

    always #5 hclk = ~hclk;

    // Bus-level ready: low while either slave stalls or another slave does.
    assign hready = !ext_stall && ro_a && ro_b;

    ahb_slave_mem #(.DEPTH(16), .BASE_ADDR(32'h0), .WAIT_STATES(1)) u_dut_ws1 (
        .hclk(hclk), .hreset(hreset), .hsel(hsel_a), .haddr(haddr),
        .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata),
        .hready(hready), .hreadyout(ro_a), .hresp(resp_a), .hrdata(rd_a)
    );

    ahb_slave_mem #(.DEPTH(16), .BASE_ADDR(32'h0), .WAIT_STATES(0)) u_dut_ws0 (
        .hclk(hclk), .hreset(hreset), .hsel(hsel_b), .haddr(haddr),
        .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata),
        .hready(hready), .hreadyout(ro_b), .hresp(resp_b), .hrdata(rd_b)
    );

    function automatic xfer_t mk(input logic wr, input logic [31:0] addr,
                                 input logic [2:0] size, input logic [31:0] data);
        xfer_t x;
        x.wr = wr; x.addr = addr; x.size = size; x.data = data;
        return x;
    endfunction

    function automatic bit legal(input logic [31:0] a, input logic [2:0] s);
        return (a < 32'd64) && (a % 4 == 0) && (s == 3'b010);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input int d, input logic ero, input logic eresp,
                              input logic [31:0] erd, input string tag);
        check({tag, ".hreadyout"}, {31'h0, (d == 0) ? ro_a : ro_b}, {31'h0, ero});
        check({tag, ".hresp"}, {31'h0, (d == 0) ? resp_a : resp_b}, {31'h0, eresp});
        check({tag, ".hrdata"}, (d == 0) ? rd_a : rd_b, erd);
    endtask

    task automatic drive_idle();
        hsel_a = 1'b0; hsel_b = 1'b0; htrans = 2'b00;
        haddr = 32'h0; hwrite = 1'b0; hsize = 3'b010;
    endtask

    task automatic drive_addr(input int d, input xfer_t x);
        hsel_a = (d == 0); hsel_b = (d == 1); htrans = 2'b10;
        haddr = x.addr; hwrite = x.wr; hsize = x.size;
    endtask

    task automatic clear_model();
        for (int k = 0; k < 16; k++) begin
            mdl[0][k] = 32'h0;
            mdl[1][k] = 32'h0;
        end
    endtask

    // Runs the queued transfers back-to-back on instance d (0: one wait
    // state, 1: none). Called #1 after a posedge; returns likewise.
    task automatic run_seq(input int d, input string name);
        int ws = (d == 0) ? 1 : 0;
        int n  = q.size();
        if (n == 0) return;
        drive_addr(d, q[0]);
        @(negedge hclk);
        check_outs(d, 1'b1, 1'b0, 32'h0, $sformatf("%s.t0addr", name));
        @(posedge hclk); #1;
        for (int i = 0; i < n; i++) begin
            bit ok  = legal(q[i].addr, q[i].size);
            int len = ok ? ws + 1 : 2;
            for (int j = 0; j < len; j++) begin
                bit          last = (j == len - 1);
                logic        ero;
                logic        eresp;
                logic [31:0] erd  = 32'h0;
                hwdata = q[i].data;
                if (j == 0) begin
                    if (i + 1 < n) drive_addr(d, q[i+1]);
                    else           drive_idle();
                end
                if (ok) begin
                    ero   = last;
                    eresp = 1'b0;
                    if (last && !q[i].wr) erd = mdl[d][q[i].addr[5:2]];
                end else begin
                    ero   = (j == 1);
                    eresp = 1'b1;
                end
                @(negedge hclk);
                check_outs(d, ero, eresp, erd, $sformatf("%s.t%0d.c%0d", name, i, j));
                @(posedge hclk);
                if (ok && last && q[i].wr) mdl[d][q[i].addr[5:2]] = q[i].data;
                #1;
            end
        end
    endtask

    initial begin
        logic [31:0] v;
        logic [31:0] a;
        logic [2:0]  s;

        clear_model();
        hreset = 1'b1; ext_stall = 1'b0; hwdata = 32'h0;
        drive_idle();
        repeat (2) @(posedge hclk);
        #1;
        check_outs(0, 1'b1, 1'b0, 32'h0, "reset.ws1");
        check_outs(1, 1'b1, 1'b0, 32'h0, "reset.ws0");
        hreset = 1'b0;

        // Write then read back with one wait state.
        q.delete();
        q.push_back(mk(1'b1, 32'h08, 3'b010, 32'hDEADBEEF));
        q.push_back(mk(1'b0, 32'h08, 3'b010, 32'h0));
        run_seq(0, "wr_rd_08");

        // Out-of-range read, then confirm memory intact.
        q.delete();
        q.push_back(mk(1'b0, 32'h40, 3'b010, 32'h0));
        q.push_back(mk(1'b0, 32'h08, 3'b010, 32'h0));
        run_seq(0, "oor_40");

        // Misaligned and wrong-size writes must not disturb 0x04.
        v = $urandom;
        q.delete();
        q.push_back(mk(1'b1, 32'h04, 3'b010, v));
        q.push_back(mk(1'b1, 32'h06, 3'b010, ~v));
        q.push_back(mk(1'b1, 32'h04, 3'b001, ~v));
        q.push_back(mk(1'b0, 32'h04, 3'b010, 32'h0));
        run_seq(0, "bad_wr");

        // Zero wait states: back-to-back writes and reads.
        q.delete();
        q.push_back(mk(1'b1, 32'h00, 3'b010, $urandom));
        q.push_back(mk(1'b1, 32'h04, 3'b010, $urandom));
        q.push_back(mk(1'b0, 32'h00, 3'b010, 32'h0));
        q.push_back(mk(1'b0, 32'h04, 3'b010, 32'h0));
        run_seq(1, "ws0_b2b");

        // Randomized traffic on both instances.
        for (int d = 0; d < 2; d++) begin
            q.delete();
            for (int k = 0; k < 24; k++) begin
                a = 32'($urandom_range(0, 17)) * 32'd4;
                if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
                s = ($urandom_range(0, 9) == 0) ? 3'b001 : 3'b010;
                q.push_back(mk(1'($urandom_range(0, 1)), a, s, $urandom));
            end
            run_seq(d, $sformatf("rand%0d", d));
        end

        // BUSY with hsel, then NONSEQ without hsel: no transfer starts.
        hsel_a = 1'b1; htrans = 2'b01; haddr = 32'h08; hwrite = 1'b0; hsize = 3'b010;
        for (int k = 0; k < 2; k++) begin
            @(negedge hclk);
            check_outs(0, 1'b1, 1'b0, 32'h0, $sformatf("busy.c%0d", k));
            @(posedge hclk); #1;
        end
        hsel_a = 1'b0; htrans = 2'b10;
        for (int k = 0; k < 2; k++) begin
            @(negedge hclk);
            check_outs(0, 1'b1, 1'b0, 32'h0, $sformatf("nosel.c%0d", k));
            @(posedge hclk); #1;
        end

        // Address phase while another slave stalls the bus is ignored.
        ext_stall = 1'b1;
        drive_addr(0, mk(1'b0, 32'h08, 3'b010, 32'h0));
        for (int k = 0; k < 3; k++) begin
            @(posedge hclk); #1;
            @(negedge hclk);
            check_outs(0, 1'b1, 1'b0, 32'h0, $sformatf("stall.c%0d", k));
        end
        @(posedge hclk); #1;
        drive_idle();
        ext_stall = 1'b0;
        @(negedge hclk);
        check_outs(0, 1'b1, 1'b0, 32'h0, "stall.after");
        @(posedge hclk); #1;

        // Reset during the wait state of a write to 0x0C.
        drive_addr(0, mk(1'b1, 32'h0C, 3'b010, 32'h12345678));
        hwdata = 32'h12345678;
        @(posedge hclk); #1;
        drive_idle();
        @(negedge hclk);
        check_outs(0, 1'b0, 1'b0, 32'h0, "rst.wait");
        #2 hreset = 1'b1;
        #1;
        check_outs(0, 1'b1, 1'b0, 32'h0, "rst.immediate");
        @(posedge hclk); #1;
        hreset = 1'b0;
        clear_model();

        q.delete();
        q.push_back(mk(1'b0, 32'h0C, 3'b010, 32'h0));
        q.push_back(mk(1'b0, 32'h08, 3'b010, 32'h0));
        run_seq(0, "post_rst");
        q.delete();
        q.push_back(mk(1'b0, 32'h00, 3'b010, 32'h0));
        run_seq(1, "post_rst0");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
